// File: rtl/trap_shaper_param.sv
// Parametrised trapezoidal shaper: circular delay line, 4-deep pipeline,
// runtime k/l/M, shifted and saturated output.
module trap_shaper_param #(
    parameter int DATA_WIDTH = 14,
    parameter int MAX_DEPTH  = 64,
    parameter int M_WIDTH    = 10,
    parameter int ACC_WIDTH  = 40,
    parameter int OUT_WIDTH  = 16,
    parameter int SHIFT      = 0,
    parameter int K_DEF      = 2,
    parameter int L_DEF      = 4,
    parameter int M_DEF      = 0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [DATA_WIDTH-1:0]      input_data,
    input  logic                       cfg_load,
    input  logic [$clog2(MAX_DEPTH):0] cfg_k,
    input  logic [$clog2(MAX_DEPTH):0] cfg_l,
    input  logic [M_WIDTH-1:0]         cfg_m,
    output logic                       out_valid,
    output logic [OUT_WIDTH-1:0]       output_data,
    output logic                       sat,
    output logic                       cfg_err
);

    localparam int AW  = $clog2(MAX_DEPTH);
    localparam int KW  = AW + 1;
    localparam int DW2 = DATA_WIDTH + 2;
    localparam int UW  = ACC_WIDTH - OUT_WIDTH + 1;

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_RELOAD = 1'b1;

    logic [DATA_WIDTH-1:0] mem_q [MAX_DEPTH];

    logic [0:0]            state_q, state_d;
    logic [KW-1:0]         k_q, k_d, l_q, l_d;
    logic [M_WIDTH-1:0]    m_q, m_d;
    logic                  err_q, err_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [KW-1:0]         fill_q, fill_d;

    logic                  vld1_q, vld1_d;
    logic [DATA_WIDTH-1:0] v1_q, v1_d, vk1_q, vk1_d;
    logic [DATA_WIDTH-1:0] vl1_q, vl1_d, vkl1_q, vkl1_d;

    logic                  vld2_q, vld2_d;
    logic signed [DW2-1:0] d2_q, d2_d;

    logic                        vld3_q, vld3_d;
    logic signed [ACC_WIDTH-1:0] p_q, p_d, md_q, md_d;

    logic                        s_vld_q, s_vld_d;
    logic signed [ACC_WIDTH-1:0] s_q, s_d;
    logic [OUT_WIDTH-1:0]        out_q, out_d;
    logic                        sat_q, sat_d;

    logic [KW:0]                 cfg_sum;
    logic                        cfg_legal;
    logic                        reload;
    logic                        accept;
    logic [KW-1:0]               kl_sum;
    logic [AW-1:0]               addr_k, addr_l, addr_kl;
    logic [DATA_WIDTH-1:0]       tap_k, tap_l, tap_kl;
    logic signed [ACC_WIDTH-1:0] d_ext, m_ext, r_val, s_nx, s_sh;
    logic [UW-1:0]               upper;
    logic                        ovf;

    always_comb begin
        cfg_sum   = {1'b0, cfg_k} + {1'b0, cfg_l};
        cfg_legal = (cfg_k != '0) && (cfg_k <= cfg_l)
                    && (cfg_sum <= (KW+1)'(MAX_DEPTH));
        reload    = cfg_load && cfg_legal;
        accept    = in_valid && !reload;

        // Taps older than the samples written since reset/reload read as 0
        kl_sum  = k_q + l_q;
        addr_k  = ptr_q - k_q[AW-1:0];
        addr_l  = ptr_q - l_q[AW-1:0];
        addr_kl = ptr_q - kl_sum[AW-1:0];
        tap_k   = (k_q <= fill_q) ? mem_q[addr_k] : '0;
        tap_l   = (l_q <= fill_q) ? mem_q[addr_l] : '0;
        tap_kl  = (kl_sum <= fill_q) ? mem_q[addr_kl] : '0;

        d_ext = {{(ACC_WIDTH-DW2){d2_q[DW2-1]}}, d2_q};
        m_ext = {{(ACC_WIDTH-M_WIDTH){1'b0}}, m_q};
        r_val = p_q + md_q;
        s_nx  = s_q + r_val;
        s_sh  = s_nx >>> SHIFT;
        upper = s_sh[ACC_WIDTH-1:OUT_WIDTH-1];
        ovf   = ~((&upper) | ~(|upper));
    end

    always_comb begin
        state_d = reload ? ST_RELOAD : ST_RUN;
        k_d     = k_q;
        l_d     = l_q;
        m_d     = m_q;
        err_d   = err_q | (cfg_load & ~cfg_legal);
        ptr_d   = ptr_q;
        fill_d  = fill_q;
        vld1_d  = accept;
        v1_d    = v1_q;
        vk1_d   = vk1_q;
        vl1_d   = vl1_q;
        vkl1_d  = vkl1_q;
        vld2_d  = vld1_q;
        d2_d    = d2_q;
        vld3_d  = vld2_q;
        p_d     = p_q;
        md_d    = md_q;
        s_vld_d = vld3_q;
        s_d     = s_q;
        out_d   = out_q;
        sat_d   = 1'b0;

        if (accept) begin
            v1_d   = input_data;
            vk1_d  = tap_k;
            vl1_d  = tap_l;
            vkl1_d = tap_kl;
            ptr_d  = ptr_q + 1'b1;
            if (fill_q != KW'(MAX_DEPTH)) begin
                fill_d = fill_q + 1'b1;
            end
        end

        if (vld1_q) begin
            d2_d = {2'b00, v1_q} - {2'b00, vk1_q}
                 - {2'b00, vl1_q} + {2'b00, vkl1_q};
        end

        if (vld2_q) begin
            p_d  = p_q + d_ext;
            md_d = d_ext * m_ext;
        end

        if (vld3_q) begin
            s_d   = s_nx;
            sat_d = ovf;
            if (ovf) begin
                out_d = s_sh[ACC_WIDTH-1]
                      ? {1'b1, {(OUT_WIDTH-1){1'b0}}}
                      : {1'b0, {(OUT_WIDTH-1){1'b1}}};
            end else begin
                out_d = s_sh[OUT_WIDTH-1:0];
            end
        end

        // A legal reload restarts the filter from an empty history
        if (reload) begin
            k_d     = cfg_k;
            l_d     = cfg_l;
            m_d     = cfg_m;
            fill_d  = '0;
            vld1_d  = 1'b0;
            vld2_d  = 1'b0;
            vld3_d  = 1'b0;
            s_vld_d = 1'b0;
            p_d     = '0;
            s_d     = '0;
            sat_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            k_q     <= KW'(K_DEF);
            l_q     <= KW'(L_DEF);
            m_q     <= M_WIDTH'(M_DEF);
            err_q   <= 1'b0;
            ptr_q   <= '0;
            fill_q  <= '0;
            vld1_q  <= 1'b0;
            v1_q    <= '0;
            vk1_q   <= '0;
            vl1_q   <= '0;
            vkl1_q  <= '0;
            vld2_q  <= 1'b0;
            d2_q    <= '0;
            vld3_q  <= 1'b0;
            p_q     <= '0;
            md_q    <= '0;
            s_vld_q <= 1'b0;
            s_q     <= '0;
            out_q   <= '0;
            sat_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            l_q     <= l_d;
            m_q     <= m_d;
            err_q   <= err_d;
            ptr_q   <= ptr_d;
            fill_q  <= fill_d;
            vld1_q  <= vld1_d;
            v1_q    <= v1_d;
            vk1_q   <= vk1_d;
            vl1_q   <= vl1_d;
            vkl1_q  <= vkl1_d;
            vld2_q  <= vld2_d;
            d2_q    <= d2_d;
            vld3_q  <= vld3_d;
            p_q     <= p_d;
            md_q    <= md_d;
            s_vld_q <= s_vld_d;
            s_q     <= s_d;
            out_q   <= out_d;
            sat_q   <= sat_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept) begin
            mem_q[ptr_q] <= input_data;
        end
    end

    assign out_valid   = s_vld_q & (state_q == ST_RUN);
    assign output_data = out_q;
    assign sat         = sat_q & out_valid;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_trap_shaper_param.sv
// Bench for trap_shaper_param: recurrence model feeds a scoreboard queue
// that is checked against every out_valid.
module tb_trap_shaper_param;

    localparam int DW = 14;
    localparam int KW = 7;
    localparam int MW = 10;
    localparam int OW = 16;
    localparam int SH = 0;
    localparam longint OMAX = (64'sd1 <<< (OW - 1)) - 1;
    localparam longint OMIN = -(64'sd1 <<< (OW - 1));

    typedef struct {
        longint d;
        logic   s;
    } exp_t;

    logic          clk = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [DW-1:0] input_data;
    logic          cfg_load;
    logic [KW-1:0] cfg_k;
    logic [KW-1:0] cfg_l;
    logic [MW-1:0] cfg_m;
    logic          out_valid;
    logic [OW-1:0] output_data;
    logic          sat;
    logic          cfg_err;

    logic signed [OW-1:0] sdata;
    assign sdata = output_data;

    trap_shaper_param #(
        .DATA_WIDTH(DW), .MAX_DEPTH(64), .M_WIDTH(MW),
        .ACC_WIDTH(40), .OUT_WIDTH(OW), .SHIFT(SH),
        .K_DEF(2), .L_DEF(4), .M_DEF(0)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .input_data(input_data), .cfg_load(cfg_load),
        .cfg_k(cfg_k), .cfg_l(cfg_l), .cfg_m(cfg_m),
        .out_valid(out_valid), .output_data(output_data),
        .sat(sat), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input longint got,
                             input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Reference model
    longint hist[$];
    longint p_m, s_m;
    int     k_m, l_m, m_m;
    logic   err_m;
    exp_t   exp_q[$];

    function automatic longint tap(input int dly);
        int n = hist.size();
        if (n - 1 - dly >= 0) return hist[n-1-dly];
        return 0;
    endfunction

    function automatic bit legal(input int k, input int l);
        return (k >= 1) && (k <= l) && (k + l <= 64);
    endfunction

    task automatic model_clear();
        hist.delete();
        p_m = 0;
        s_m = 0;
        exp_q.delete();
    endtask

    task automatic model_step(input longint v);
        longint d, sh;
        exp_t   e;
        hist.push_back(v);
        d   = v - tap(k_m) - tap(l_m) + tap(k_m + l_m);
        p_m = p_m + d;
        s_m = s_m + p_m + longint'(m_m) * d;
        sh  = s_m >>> SH;
        e.s = 1'b1;
        if (sh > OMAX) e.d = OMAX;
        else if (sh < OMIN) e.d = OMIN;
        else begin
            e.d = sh;
            e.s = 1'b0;
        end
        exp_q.push_back(e);
    endtask

    // Monitor
    int     cyc = 0;
    int     lat_start = 0;
    bit     lat_req = 0;
    bit     lat_arm = 0;
    int     sat_cnt = 0;
    longint obs[$];
    exp_t   mon_e;

    always @(posedge clk) cyc = cyc + 1;

    always @(posedge clk) begin
        #1;
        if (out_valid) begin
            obs.push_back(sdata);
            if (sat) sat_cnt++;
            if (exp_q.size() == 0) begin
                check_val("unexpected_out", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("data", sdata, mon_e.d);
                check_val("sat", sat, mon_e.s);
            end
            if (lat_arm) begin
                check_val("latency", cyc - lat_start, 4);
                lat_arm = 0;
            end
        end else if (sat) begin
            check_val("sat_idle", sat, 0);
        end
    end

    // One clock of stimulus, applied at a falling edge
    task automatic cycle(input logic iv, input longint v, input logic ld,
                         input int k, input int l, input int m);
        in_valid   = iv;
        input_data = DW'(v);
        cfg_load   = ld;
        cfg_k      = KW'(k);
        cfg_l      = KW'(l);
        cfg_m      = MW'(m);
        if (ld && legal(k, l)) begin
            k_m = k;
            l_m = l;
            m_m = m;
            model_clear();
        end else begin
            if (ld) err_m = 1'b1;
            if (iv) begin
                model_step(v);
                if (lat_req) begin
                    lat_start = cyc;
                    lat_arm   = 1;
                    lat_req   = 0;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic sample(input longint v);
        cycle(1'b1, v, 1'b0, 0, 0, 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 0, 1'b0, 0, 0, 0);
    endtask

    task automatic load(input int k, input int l, input int m);
        cycle(1'b0, 0, 1'b1, k, l, m);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        cfg_load = 1'b0;
        k_m = 2;
        l_m = 4;
        m_m = 0;
        err_m = 1'b0;
        model_clear();
        @(negedge clk);
        reset = 1'b0;
    endtask

    longint ref_step[12];
    longint imp_tbl[7] = '{40, 50, 20, 20, -20, -30, 0};
    int     base;

    initial begin
        reset      = 1'b1;
        in_valid   = 1'b0;
        input_data = '0;
        cfg_load   = 1'b0;
        cfg_k      = '0;
        cfg_l      = '0;
        cfg_m      = '0;
        k_m = 2;
        l_m = 4;
        m_m = 0;
        err_m = 1'b0;
        p_m = 0;
        s_m = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_output_data", output_data, 0);
        check_val("rst_sat", sat, 0);
        check_val("rst_cfg_err", cfg_err, 0);

        // Step with reset-default k/l/M
        base    = obs.size();
        lat_req = 1;
        for (int i = 0; i < 12; i++) sample(100);
        idle(8);
        check_val("step_cnt", obs.size() - base, 12);
        for (int i = 0; i < 12 && base + i < obs.size(); i++)
            ref_step[i] = obs[base+i];

        // Impulse with M = 3
        load(2, 4, 3);
        base = obs.size();
        sample(10);
        for (int i = 0; i < 9; i++) sample(0);
        idle(8);
        check_val("impulse_cnt", obs.size() - base, 10);
        for (int i = 0; i < 7 && base + i < obs.size(); i++)
            check_val("impulse_tbl", obs[base+i], imp_tbl[i]);

        // Same impulse, in_valid every third cycle
        load(2, 4, 3);
        base = obs.size();
        sample(10);
        idle(2);
        for (int i = 0; i < 9; i++) begin
            sample(0);
            idle(2);
        end
        idle(8);
        check_val("gap_cnt", obs.size() - base, 10);
        for (int i = 0; i < 7 && base + i < obs.size(); i++)
            check_val("gap_tbl", obs[base+i], imp_tbl[i]);

        // Illegal then legal mid-stream reconfiguration
        load(2, 4, 0);
        for (int i = 0; i < 4; i++) sample(100);
        cycle(1'b1, 100, 1'b1, 5, 3, 0);
        for (int i = 0; i < 3; i++) sample(100);
        check_val("cfg_err_set", cfg_err, err_m);
        cycle(1'b1, 100, 1'b1, 3, 3, 0);
        check_val("reload_ov", out_valid, 0);
        for (int i = 0; i < 8; i++) sample(100);
        idle(8);
        check_val("cfg_err_sticky", cfg_err, err_m);

        // Saturation with long taps
        load(32, 32, 0);
        for (int i = 0; i < 10; i++) sample(16383);
        for (int i = 0; i < 4; i++) sample(0);
        idle(8);
        check_val("sat_seen", sat_cnt > 0, 1);

        // Reset during a running step
        for (int i = 0; i < 6; i++) sample(100);
        do_reset();
        check_val("mid_rst_ov", out_valid, 0);
        check_val("mid_rst_data", output_data, 0);
        check_val("mid_rst_err", cfg_err, 0);
        idle(6);
        base    = obs.size();
        lat_req = 1;
        for (int i = 0; i < 12; i++) sample(100);
        idle(8);
        check_val("restep_cnt", obs.size() - base, 12);
        for (int i = 0; i < 12 && base + i < obs.size(); i++)
            check_val("restep", obs[base+i], ref_step[i]);

        check_val("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
